// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards
// EX/MEM and MEM/WB results into the ALU operands, flags load-use.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic            id_rs1_used_i,
  input  logic            id_rs2_used_i,
  input  logic [RA_W-1:0] id_rd_i,
  input  logic            id_wb_en_i,
  input  logic            id_is_load_i,
  input  logic            id_src1_pc_i,
  input  logic            id_src2_imm_i,
  input  logic [3:0]      id_func_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            exm_wb_en_i,
  input  logic [RA_W-1:0] exm_rd_i,
  input  logic [XLEN-1:0] exm_result_i,
  input  logic            mwb_wb_en_i,
  input  logic [RA_W-1:0] mwb_rd_i,
  input  logic [XLEN-1:0] mwb_result_i,
  output logic [XLEN-1:0] src1_o,
  output logic [XLEN-1:0] src2_o,
  output logic [3:0]      func_o,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] rs2_fwd_o,
  output logic [RA_W-1:0] rd_o,
  output logic            wb_en_o,
  output logic            is_load_o,
  output logic            load_use_o
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            wb_en;
    logic            is_load;
    logic            src1_pc;
    logic            src2_imm;
    logic [3:0]      func;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;
  id_ex_t cap;

  logic            ex_hit1;
  logic            ex_hit2;
  logic            mw_hit1;
  logic            mw_hit2;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic            rs1_match;
  logic            rs2_match;

  always_comb begin
    cap.valid    = id_valid_i;
    cap.pc       = id_pc_i;
    cap.rs1_data = id_rs1_data_i;
    cap.rs2_data = id_rs2_data_i;
    cap.imm      = id_imm_i;
    cap.rs1      = id_rs1_i;
    cap.rs2      = id_rs2_i;
    cap.rd       = id_rd_i;
    cap.wb_en    = id_wb_en_i;
    cap.is_load  = id_is_load_i;
    cap.src1_pc  = id_src1_pc_i;
    cap.src2_imm = id_src2_imm_i;
    cap.func     = id_func_i;
  end

  // x0 is hardwired zero, so a write to it is never a forwarding source
  assign ex_hit1 = exm_wb_en_i && (exm_rd_i == q.rs1) && (|q.rs1);
  assign ex_hit2 = exm_wb_en_i && (exm_rd_i == q.rs2) && (|q.rs2);
  assign mw_hit1 = mwb_wb_en_i && (mwb_rd_i == q.rs1) && (|q.rs1);
  assign mw_hit2 = mwb_wb_en_i && (mwb_rd_i == q.rs2) && (|q.rs2);

  always_comb begin
    fwd1 = q.rs1_data;
    if (ex_hit1) fwd1 = exm_result_i;
    else if (mw_hit1) fwd1 = mwb_result_i;
  end

  always_comb begin
    fwd2 = q.rs2_data;
    if (ex_hit2) fwd2 = exm_result_i;
    else if (mw_hit2) fwd2 = mwb_result_i;
  end

  assign rs1_match = id_rs1_used_i && (id_rs1_i == q.rd);
  assign rs2_match = id_rs2_used_i && (id_rs2_i == q.rd);

  assign load_use_o = q.valid && q.is_load && (|q.rd) &&
                      id_valid_i && (rs1_match || rs2_match);

  // Stall keeps the operands live so a producer retiring mid-stall is kept
  always_comb begin
    d = q;
    if (flush_i) begin
      d = '0;
    end else if (stall_i) begin
      d.rs1_data = fwd1;
      d.rs2_data = fwd2;
    end else if (load_use_o) begin
      d = '0;
    end else begin
      d = cap;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) q <= '0;
    else          q <= d;
  end

  assign src1_o    = q.src1_pc  ? q.pc  : fwd1;
  assign src2_o    = q.src2_imm ? q.imm : fwd2;
  assign rs2_fwd_o = fwd2;
  assign func_o    = q.func;
  assign valid_o   = q.valid;
  assign pc_o      = q.pc;
  assign rd_o      = q.rd;
  assign wb_en_o   = q.valid && q.wb_en;
  assign is_load_o = q.valid && q.is_load;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hazard,
// stall, flush and async-reset sequences.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_rs1_data_i;
  logic [31:0] id_rs2_data_i;
  logic [31:0] id_imm_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic [4:0]  id_rd_i;
  logic        id_wb_en_i;
  logic        id_is_load_i;
  logic        id_src1_pc_i;
  logic        id_src2_imm_i;
  logic [3:0]  id_func_i;
  logic        stall_i;
  logic        flush_i;
  logic        exm_wb_en_i;
  logic [4:0]  exm_rd_i;
  logic [31:0] exm_result_i;
  logic        mwb_wb_en_i;
  logic [4:0]  mwb_rd_i;
  logic [31:0] mwb_result_i;
  logic [31:0] src1_o;
  logic [31:0] src2_o;
  logic [3:0]  func_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] rs2_fwd_o;
  logic [4:0]  rd_o;
  logic        wb_en_o;
  logic        is_load_o;
  logic        load_use_o;

  int errs = 0;
  int checks = 0;

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rd_i(id_rd_i), .id_wb_en_i(id_wb_en_i),
    .id_is_load_i(id_is_load_i), .id_src1_pc_i(id_src1_pc_i),
    .id_src2_imm_i(id_src2_imm_i), .id_func_i(id_func_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .exm_wb_en_i(exm_wb_en_i), .exm_rd_i(exm_rd_i),
    .exm_result_i(exm_result_i),
    .mwb_wb_en_i(mwb_wb_en_i), .mwb_rd_i(mwb_rd_i),
    .mwb_result_i(mwb_result_i),
    .src1_o(src1_o), .src2_o(src2_o), .func_o(func_o),
    .valid_o(valid_o), .pc_o(pc_o), .rs2_fwd_o(rs2_fwd_o),
    .rd_o(rd_o), .wb_en_o(wb_en_o), .is_load_o(is_load_o),
    .load_use_o(load_use_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] v, pc, r1d, r2d, imm, r1, r2, rd;
    logic [31:0] u1, u2, wb, ld, s1pc, s2imm, fn;
    logic [31:0] stall, flush;
    logic [31:0] exw, exrd, exres, mww, mwrd, mwres;
    logic [31:0] e_v, e_wb, e_ld, e_s1, e_s2, e_r2f, e_fn;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_fwd;
    exm_wb_en_i = 1'b0; exm_rd_i = '0; exm_result_i = '0;
    mwb_wb_en_i = 1'b0; mwb_rd_i = '0; mwb_result_i = '0;
  endtask

  task automatic drive(input vec_t t);
    id_valid_i    = t.v[0];
    id_pc_i       = t.pc;
    id_rs1_data_i = t.r1d;
    id_rs2_data_i = t.r2d;
    id_imm_i      = t.imm;
    id_rs1_i      = t.r1[4:0];
    id_rs2_i      = t.r2[4:0];
    id_rd_i       = t.rd[4:0];
    id_rs1_used_i = t.u1[0];
    id_rs2_used_i = t.u2[0];
    id_wb_en_i    = t.wb[0];
    id_is_load_i  = t.ld[0];
    id_src1_pc_i  = t.s1pc[0];
    id_src2_imm_i = t.s2imm[0];
    id_func_i     = t.fn[3:0];
    stall_i       = t.stall[0];
    flush_i       = t.flush[0];
    exm_wb_en_i   = t.exw[0];
    exm_rd_i      = t.exrd[4:0];
    exm_result_i  = t.exres;
    mwb_wb_en_i   = t.mww[0];
    mwb_rd_i      = t.mwrd[4:0];
    mwb_result_i  = t.mwres;
  endtask

  initial begin
    //        v pc     r1d      r2d    imm  r1 r2 rd u1 u2 wb ld s1 s2 fn
    //        st fl exw exrd exres    mww mwrd mwres
    //        e_v e_wb e_ld e_s1     e_s2  e_r2f e_fn
    tbl[0]  = '{1, 'h100, 'h5, 'h7, 0, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0,
                1, 1, 0, 'h5, 'h7, 'h7, 0};
    tbl[1]  = '{1, 'h104, 'h9, 'h33, 'h20, 1, 0, 4, 1, 0, 1, 0, 0, 1, 2,
                0, 0, 0, 0, 0, 0, 0, 0,
                1, 1, 0, 'h9, 'h20, 'h33, 2};
    tbl[2]  = '{1, 'h200, 'h99, 0, 4, 1, 0, 1, 0, 0, 1, 0, 1, 1, 5,
                0, 0, 0, 0, 0, 0, 0, 0,
                1, 1, 0, 'h200, 4, 0, 5};
    tbl[3]  = '{1, 'h108, 'h11, 'h22, 0, 3, 2, 4, 1, 1, 1, 0, 0, 0, 1,
                0, 0, 1, 3, 'h10, 0, 0, 0,
                1, 1, 0, 'h10, 'h22, 'h22, 1};
    tbl[4]  = '{1, 'h10C, 'h11, 'h22, 0, 3, 2, 4, 1, 1, 1, 0, 0, 0, 1,
                0, 0, 1, 3, 'h10, 1, 3, 'h20,
                1, 1, 0, 'h10, 'h22, 'h22, 1};
    tbl[5]  = '{1, 'h110, 'h11, 'h22, 0, 3, 2, 4, 1, 1, 0, 0, 0, 0, 7,
                0, 0, 0, 0, 0, 1, 2, 'h77,
                1, 0, 0, 'h11, 'h77, 'h77, 7};
    tbl[6]  = '{1, 'h114, 'h11, 'h22, 0, 3, 2, 4, 1, 1, 1, 0, 0, 0, 8,
                0, 0, 0, 3, 'h10, 1, 3, 'h20,
                1, 1, 0, 'h20, 'h22, 'h22, 8};
    tbl[7]  = '{1, 'h118, 0, 'h22, 0, 0, 2, 4, 1, 1, 1, 0, 0, 0, 'hF,
                0, 0, 1, 0, 'hDEAD, 0, 0, 0,
                1, 1, 0, 0, 'h22, 'h22, 'hF};
    tbl[8]  = '{0, 'h180, 'h44, 'h45, 0, 6, 7, 9, 1, 1, 1, 1, 0, 0, 3,
                0, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 'h44, 'h45, 'h45, 3};
    tbl[9]  = '{1, 'h1C0, 'h66, 'h67, 'h8, 6, 7, 9, 1, 1, 1, 1, 0, 0, 3,
                0, 1, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 'h240, 'h1000, 0, 8, 1, 0, 5, 1, 0, 1, 1, 0, 1, 0,
                0, 0, 0, 0, 0, 0, 0, 0,
                1, 1, 1, 'h1000, 8, 0, 0};

    reset_i = 1'b0;
    drive('{default: 0});
    #12;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_func", 32'(func_o), 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_rd", 32'(rd_o), 0);
    chk("rst_wb_en", 32'(wb_en_o), 0);
    chk("rst_is_load", 32'(is_load_o), 0);
    chk("rst_load_use", 32'(load_use_o), 0);
    reset_i = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i]);
      step();
      chk($sformatf("v%0d_valid", i), 32'(valid_o), tbl[i].e_v);
      chk($sformatf("v%0d_wb_en", i), 32'(wb_en_o), tbl[i].e_wb);
      chk($sformatf("v%0d_is_load", i), 32'(is_load_o), tbl[i].e_ld);
      chk($sformatf("v%0d_src1", i), src1_o, tbl[i].e_s1);
      chk($sformatf("v%0d_src2", i), src2_o, tbl[i].e_s2);
      chk($sformatf("v%0d_rs2_fwd", i), rs2_fwd_o, tbl[i].e_r2f);
      chk($sformatf("v%0d_func", i), 32'(func_o), tbl[i].e_fn);
      chk($sformatf("v%0d_pc", i), pc_o,
          tbl[i].flush[0] ? 32'h0 : tbl[i].pc);
      chk($sformatf("v%0d_rd", i), 32'(rd_o),
          tbl[i].flush[0] ? 32'h0 : tbl[i].rd);
      chk($sformatf("v%0d_load_use", i), 32'(load_use_o), 0);
    end

    // Load-use: LW x5 held, decode presents ADD x6 = x5 + x1
    id_valid_i = 1'b0; id_pc_i = 32'h244;
    id_rs1_i = 5'd5; id_rs2_i = 5'd1;
    id_rs1_used_i = 1'b1; id_rs2_used_i = 1'b1;
    id_rs1_data_i = 32'hBAD; id_rs2_data_i = 32'h3;
    id_imm_i = '0; id_rd_i = 5'd6; id_wb_en_i = 1'b1;
    id_is_load_i = 1'b0; id_src1_pc_i = 1'b0; id_src2_imm_i = 1'b0;
    id_func_i = 4'h0;
    #1;
    chk("lu_idle_decode", 32'(load_use_o), 0);
    id_valid_i = 1'b1;
    #1;
    chk("lu_flag", 32'(load_use_o), 1);
    step();
    chk("lu_bubble_valid", 32'(valid_o), 0);
    chk("lu_bubble_wb_en", 32'(wb_en_o), 0);
    chk("lu_after_bubble", 32'(load_use_o), 0);
    mwb_wb_en_i = 1'b1; mwb_rd_i = 5'd5; mwb_result_i = 32'h99;
    step();
    chk("lu_add_valid", 32'(valid_o), 1);
    chk("lu_add_src1", src1_o, 32'h99);
    chk("lu_add_src2", src2_o, 32'h3);
    chk("lu_add_pc", pc_o, 32'h244);

    // Multi-cycle stall while the rs2 producer passes EX/MEM then MEM/WB
    clr_fwd();
    id_pc_i = 32'h300; id_rs1_i = 5'd1; id_rs1_data_i = 32'h1;
    id_rs2_i = 5'd7; id_rs2_data_i = 32'hBAD; id_rd_i = 5'd8;
    id_func_i = 4'h1;
    step();
    chk("st_pre_src2", src2_o, 32'hBAD);
    stall_i = 1'b1;
    id_pc_i = 32'h400; id_rs2_data_i = 32'h1234;
    exm_wb_en_i = 1'b1; exm_rd_i = 5'd7; exm_result_i = 32'h55;
    #1;
    chk("st_exm_src2", src2_o, 32'h55);
    step();
    clr_fwd();
    mwb_wb_en_i = 1'b1; mwb_rd_i = 5'd7; mwb_result_i = 32'h55;
    step();
    clr_fwd();
    step();
    stall_i = 1'b0;
    #1;
    chk("st_rel_src2", src2_o, 32'h55);
    chk("st_rel_rs2_fwd", rs2_fwd_o, 32'h55);
    chk("st_rel_pc", pc_o, 32'h300);
    chk("st_rel_valid", 32'(valid_o), 1);
    chk("st_rel_func", 32'(func_o), 1);

    // Flush wins over a simultaneous stall
    flush_i = 1'b1; stall_i = 1'b1;
    step();
    chk("fs_valid", 32'(valid_o), 0);
    chk("fs_wb_en", 32'(wb_en_o), 0);
    flush_i = 1'b0; stall_i = 1'b0;

    // Asynchronous reset between edges
    id_pc_i = 32'h500; id_func_i = 4'hA; id_rs1_used_i = 1'b0;
    id_rs2_used_i = 1'b0;
    step();
    chk("ar_pre_valid", 32'(valid_o), 1);
    chk("ar_pre_func", 32'(func_o), 32'hA);
    #2;
    reset_i = 1'b0;
    #1;
    chk("ar_valid", 32'(valid_o), 0);
    chk("ar_func", 32'(func_o), 0);
    chk("ar_pc", pc_o, 0);
    reset_i = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode/execute pipeline register that feeds the ALU its src1, src2 and 4-bit func each cycle. Holds one decoded instruction with stall, flush and bubble control. Resolves EX/MEM and MEM/WB data hazards by forwarding, and flags load-use hazards back to decode.

Parameters:
XLEN, 32, datapath width.
RA_W, 5, register address width.

Ports:
clk_i  input  1  core clock, all state updates on rising edge
reset_i  input  1  asynchronous active-low reset
id_valid_i  input  1  decode presents an instruction
id_pc_i  input  XLEN  instruction PC
id_rs1_data_i  input  XLEN  register-file read data 1
id_rs2_data_i  input  XLEN  register-file read data 2
id_imm_i  input  XLEN  sign-extended immediate
id_rs1_i  input  RA_W  rs1 address
id_rs2_i  input  RA_W  rs2 address
id_rs1_used_i  input  1  instruction reads rs1
id_rs2_used_i  input  1  instruction reads rs2
id_rd_i  input  RA_W  destination address
id_wb_en_i  input  1  instruction writes rd
id_is_load_i  input  1  instruction is a load
id_src1_pc_i  input  1  src1 selects PC instead of rs1
id_src2_imm_i  input  1  src2 selects immediate instead of rs2
id_func_i  input  4  ALU function code
stall_i  input  1  hold stage contents
flush_i  input  1  kill stage contents
exm_wb_en_i  input  1  EX/MEM instruction writes rd
exm_rd_i  input  RA_W  EX/MEM destination
exm_result_i  input  XLEN  EX/MEM result
mwb_wb_en_i  input  1  MEM/WB instruction writes rd
mwb_rd_i  input  RA_W  MEM/WB destination
mwb_result_i  input  XLEN  MEM/WB writeback data
src1_o  output  XLEN  ALU operand 1
src2_o  output  XLEN  ALU operand 2
func_o  output  4  ALU function code
valid_o  output  1  stage holds a live instruction
pc_o  output  XLEN  held PC
rs2_fwd_o  output  XLEN  forwarded rs2 (store data)
rd_o  output  RA_W  held destination
wb_en_o  output  1  valid_o AND held wb_en
is_load_o  output  1  valid_o AND held is_load
load_use_o  output  1  load-use hazard, decode must stall

Behaviour:
- Reset (reset_i low, asynchronous): all registers 0. valid_o=0, wb_en_o=0, is_load_o=0, load_use_o=0, func_o=4'b0000, pc_o=0, rd_o=0.
- Per-edge priority: flush_i > stall_i > load_use_o > capture.
- flush_i=1: capture a bubble. Bubble means valid, wb_en and is_load=0; data fields don't-care, set to 0. Flush wins over a simultaneous stall.
- stall_i=1: hold all fields. Still refresh the held rs1/rs2 values with the forwarded values, so a producer retiring during a multi-cycle stall is not lost.
- load_use_o=1 with stall_i=0: capture a bubble. Decode holds its instruction and presents it again next cycle.
- Otherwise: capture all id_* fields. valid is captured from id_valid_i.
- Forwarding is combinational on the held rs1/rs2. Priority: EX/MEM, then MEM/WB, then held register data. A path applies only when its wb_en is 1, its rd equals the source address, and that address is non-zero. x0 is never forwarded.
- src1_o = held pc if src1_pc, else forwarded rs1. src2_o = held imm if src2_imm, else forwarded rs2. rs2_fwd_o is always forwarded rs2.
- func_o passes the held func unchanged. The PC+4 function uses src1_pc=1.
- Latency: one cycle from decode to ALU operands; no combinational path from id_* to src*_o.
- load_use_o = valid_o AND held is_load AND held rd!=0 AND id_valid_i AND a source match. A source match is (id_rs1_used_i AND id_rs1_i==rd) OR (id_rs2_used_i AND id_rs2_i==rd). load_use_o is combinational.

Test Plan:
- Reset mid-operation: hold valid instruction, drop reset_i between edges -> valid_o=0, func_o=0 immediately, no wait for clock.
- Back-to-back ADD x3=x1+x2 then SUB x4=x3-x1, exm rd=3 result=0x10 -> cycle 2 src1_o=0x10; with exm and mwb both rd=3 (0x10, 0x20) -> 0x10.
- x0 guard: exm_wb_en=1, rd=0, result=0xDEAD, held rs1=0, regfile 0 -> src1_o=0.
- Load-use: LW x5 held, decode ADD x6=x5+x1 -> load_use_o=1; next edge valid_o=0; following edge ADD captured, src1_o=mwb_result when mwb_rd=5.
- Stall 3 cycles while rs2=7 producer passes exm then mwb (0x55) then leaves -> after release src2_o=0x55, not stale regfile value.
- flush_i and stall_i both high -> valid_o=0, wb_en_o=0 next edge.
